// File: rtl/ram_arbiter.sv
// ram_arbiter
// Owns the 256x8 system RAM and shares it between the CPU memory port and a
// debug/loader port. The CPU keeps its active-low R/W strobes and gets
// combinational read data. The debug port uses a req/ack handshake. It is
// served in CPU-idle cycles. If the CPU stays busy for STARVE_LIMIT wait
// cycles, a debug access is forced and cpu_hold is raised for that cycle.
//
// Ports:
//   clk, rst               clock, asynchronous active-high reset
//   cpu_R, cpu_W           CPU read/write strobes (active low)
//   cpu_addr, cpu_wdata    CPU address / write data
//   cpu_rdata              mem[cpu_addr] while cpu_R=0, else 0x00 (combinational)
//   cpu_hold               forced debug cycle; the CPU access is not performed
//   dbg_req, dbg_we        debug request (held until ack), 1=write / 0=read
//   dbg_addr, dbg_wdata    debug address / write data
//   dbg_ack                one-cycle completion pulse
//   dbg_rdata              registered debug read data, held until the next read
//   conflict               sticky flag: CPU drove R and W low together
module ram_arbiter #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cpu_R,
  input  logic       cpu_W,
  input  logic [7:0] cpu_addr,
  input  logic [7:0] cpu_wdata,
  output logic [7:0] cpu_rdata,
  output logic       cpu_hold,
  input  logic       dbg_req,
  input  logic       dbg_we,
  input  logic [7:0] dbg_addr,
  input  logic [7:0] dbg_wdata,
  output logic       dbg_ack,
  output logic [7:0] dbg_rdata,
  output logic       conflict
);

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_ACK  = 2'd2
  } state_t;

  state_t     state_q;
  logic [3:0] cnt_q;
  logic       dbg_ack_q;
  logic [7:0] dbg_rdata_q;
  logic       conflict_q;

  // Not reset: contents survive rst.
  logic [7:0] mem [0:255];

  logic cpu_idle;
  logic starved;
  logic dbg_go;
  logic dbg_wr;
  logic cpu_wr;

  assign cpu_idle = cpu_R & cpu_W;
  assign starved  = (state_q == S_WAIT) && (cnt_q == LIMIT);
  // The debug access fires either in a CPU-idle cycle or in the forced cycle.
  assign dbg_go   = (state_q == S_WAIT) && (cpu_idle || (cnt_q == LIMIT));
  assign dbg_wr   = dbg_go & dbg_we;
  // R and W low together counts as a read only; a hold cycle drops the write.
  assign cpu_wr   = ~cpu_W & cpu_R & ~starved;

  assign cpu_hold  = starved;
  assign cpu_rdata = cpu_R ? 8'h00 : mem[cpu_addr];
  assign dbg_ack   = dbg_ack_q;
  assign dbg_rdata = dbg_rdata_q;
  assign conflict  = conflict_q;

  // Single write port. The debug write only happens when the CPU is idle or
  // held, so the two writers never both want the port in the same cycle.
  always_ff @(posedge clk) begin
    if (dbg_wr) begin
      mem[dbg_addr] <= dbg_wdata;
    end else if (cpu_wr) begin
      mem[cpu_addr] <= cpu_wdata;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= 4'd0;
      dbg_ack_q   <= 1'b0;
      dbg_rdata_q <= 8'h00;
      conflict_q  <= 1'b0;
    end else begin
      dbg_ack_q <= 1'b0;
      if (!cpu_R && !cpu_W) begin
        conflict_q <= 1'b1;
      end
      unique case (state_q)
        S_IDLE: begin
          if (dbg_req) begin
            state_q <= S_WAIT;
            cnt_q   <= 4'd0;
          end
        end
        S_WAIT: begin
          if (dbg_go) begin
            // Reads capture pre-edge contents; writes leave dbg_rdata alone.
            if (!dbg_we) begin
              dbg_rdata_q <= mem[dbg_addr];
            end
            state_q   <= S_ACK;
            dbg_ack_q <= 1'b1;
          end else if (cnt_q < LIMIT) begin
            cnt_q <= cnt_q + 4'd1;
          end
        end
        S_ACK: begin
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/ram_arbiter.md
# ram_arbiter

Owns the 256-byte system RAM and shares it between the dCPU memory port and a secondary debug/loader port. The dCPU keeps its existing active-low R/W protocol with combinational read data. The debug port uses a req/ack handshake and is served in CPU-idle cycles. A starvation counter forces a debug access and raises `cpu_hold` if the CPU never goes idle.

## Interface
- `STARVE_LIMIT`, 4: number of busy-CPU wait cycles before a debug access is forced (1..15).
- `clk`  in  1  system clock; all state updates on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `cpu_R`  in  1  CPU read strobe, active low.
- `cpu_W`  in  1  CPU write strobe, active low.
- `cpu_addr`  in  8  CPU byte address.
- `cpu_wdata`  in  8  CPU write data.
- `cpu_rdata`  out  8  combinational read data: `mem[cpu_addr]` when `cpu_R`=0, else 0x00.
- `cpu_hold`  out  1  forced-access cycle; the CPU must treat its current access as not performed.
- `dbg_req`  in  1  debug request; held high with address/data stable until `dbg_ack`.
- `dbg_we`  in  1  1 = write, 0 = read.
- `dbg_addr`  in  8  debug byte address.
- `dbg_wdata`  in  8  debug write data.
- `dbg_ack`  out  1  one-cycle completion pulse.
- `dbg_rdata`  out  8  registered read data; valid with `dbg_ack`, held until the next debug read.
- `conflict`  out  1  sticky error: CPU drove R and W low together.

## Operation
- Memory is a 256x8 array and is not cleared by `rst`. Contents survive reset.
- CPU is idle when `cpu_R`=1 and `cpu_W`=1; otherwise it is busy.
- CPU write: at the rising edge, if `cpu_W`=0, `cpu_R`=1 and `cpu_hold`=0, then `mem[cpu_addr]` <= `cpu_wdata`.
- CPU R=0 and W=0 together: the write is suppressed, the read is still served, and `conflict` sets at that edge. It stays 1 until `rst`.
- Debug FSM has three states: IDLE, WAIT, ACK.
  - IDLE: if `dbg_req`=1, go to WAIT and clear `cnt`.
  - WAIT, CPU idle or `cnt`==`STARVE_LIMIT`: perform the debug access at the edge (write to mem, or capture `mem[dbg_addr]` into `dbg_rdata`), then go to ACK.
  - WAIT, CPU busy and `cnt`<`STARVE_LIMIT`: `cnt`++ and stay in WAIT.
  - ACK: `dbg_ack`=1, then unconditionally go to IDLE. If `dbg_req` is still high in IDLE, a new request starts (back-to-back).
- `cpu_hold` = (state==WAIT && `cnt`==`STARVE_LIMIT`), combinational. In a hold cycle, any CPU write is dropped. CPU reads are still served and return pre-edge contents.
- Same-address debug write and CPU read in one cycle: the CPU sees the old value, the new value appears the next cycle.
- A debug write needs no `dbg_rdata` update.
- `cnt` is 4 bits and saturates at `STARVE_LIMIT`; it never wraps.

## Timing
- Reset values:
  - state = IDLE, `cnt` = 0.
  - `dbg_ack` = 0, `dbg_rdata` = 0x00, `conflict` = 0, `cpu_hold` = 0.
  - `cpu_rdata` follows its combinational rule.
- Reset mid-operation: any pending or acknowledging request is dropped with no ack and no memory side effect. The requester reissues the request. A still-high `dbg_req` is seen at the first edge after `rst` falls.
- Cycle k is the period after edge k, with `dbg_req` first high in cycle 0.
  - WAIT runs from cycle 1.
  - CPU idle in cycle 1: access at edge 2, `dbg_ack` in cycle 2. Minimum latency is 2 cycles.
  - CPU always busy: `cnt` reaches `STARVE_LIMIT` in cycle `STARVE_LIMIT`+1, and `cpu_hold` is high that cycle only. Access happens at the next edge and ack follows one cycle later. Worst case is `STARVE_LIMIT`+2 cycles.
- CPU read latency is 0 (combinational). CPU write is visible from the cycle after its edge.

## Test plan
- Reset with `rst` pulsed: all outputs at reset values. A memory byte written before reset reads back unchanged after it.
- CPU `cpu_W`=0, addr 0xFE, data 0x63 for one cycle, then `cpu_R`=0 addr 0xFE -> `cpu_rdata`=0x63. With `cpu_R`=1 -> 0x00.
- CPU idle, debug write 0xA5 to 0x10 -> `dbg_ack` in cycle 2 only. A CPU read of 0x10 afterwards -> 0xA5.
- `STARVE_LIMIT`=4, CPU holds `cpu_R`=0 continuously, debug read of 0xFE (containing 0x63) -> `cpu_hold` high in cycle 5 only, `dbg_ack` in cycle 6, `dbg_rdata`=0x63. A CPU write issued in cycle 5 is absent from memory.
- `cpu_R`=`cpu_W`=0, addr 0x20, data 0xFF, mem[0x20]=0x11 -> mem[0x20] stays 0x11, `conflict`=1 and remains 1 through further traffic until `rst`.
- `rst` asserted in cycle 2 of a busy-CPU debug write to 0x30 -> no `dbg_ack`, mem[0x30] unchanged. The request restarts after reset and completes normally.
